lc3b_fetch: RTL and testbench

- Instruction-fetch stage of the LC-3b pipeline. Sits directly upstream of the IF/ID register.
- Owns the PC and drives the instruction-memory read handshake (mem_read / mem_resp).
- Presents a registered instruction plus its PC+2 to IF/ID under a valid/stall handshake.
- Accepts branch/jump redirects and squashes any fetch already in flight.

---
 rtl/lc3b_fetch.sv | 150 +++++++++++++++
 tb/tb_lc3b_fetch.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3b_fetch.sv
// lc3b_fetch: LC-3b instruction-fetch stage feeding the IF/ID register.
// Owns the PC, runs the imem read handshake, and presents a registered
// instruction with its PC+2 under a valid/stall handshake.
// Ports:
//   clk, reset             clock, async active-high reset
//   stall                  downstream cannot accept this cycle
//   redirect, redirect_pc  branch/jump target load, flushes the stage
//   mem_resp, mem_rdata    imem response handshake and data
//   mem_read, mem_address  imem request (held until mem_resp)
//   instr_out, pc_out      fetched instruction and its address + 2
//   valid_out              instr_out/pc_out hold a live instruction
module lc3b_fetch #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   input  logic        mem_resp,
   input  logic [15:0] mem_rdata,
   output logic        mem_read,
   output logic [15:0] mem_address,
   output logic [15:0] instr_out,
   output logic [15:0] pc_out,
   output logic        valid_out
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_DRAIN
   } state_e;

   localparam logic [15:0] RESET_PC_AL = {RESET_PC[15:1], 1'b0};

   state_e      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] req_addr_q, req_addr_d;
   logic        squash_q, squash_d;
   logic        skid_valid_q, skid_valid_d;
   logic [15:0] skid_instr_q, skid_instr_d;
   logic [15:0] skid_pc_q, skid_pc_d;
   logic [15:0] instr_q, instr_d;
   logic [15:0] pcout_q, pcout_d;
   logic        valid_q, valid_d;

   logic        in_req;
   logic        resp_hit;
   logic        resp_take;
   logic        retire;
   logic        holding;
   logic [15:0] next_addr;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      req_addr_d   = req_addr_q;
      squash_d     = squash_q;
      skid_valid_d = skid_valid_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;
      instr_d      = instr_q;
      pcout_d      = pcout_q;
      valid_d      = valid_q;

      in_req    = (state_q == S_REQ);
      resp_hit  = in_req && mem_resp;
      resp_take = resp_hit && !squash_q;
      retire    = valid_q && !stall;
      next_addr = req_addr_q + 16'd2;

      if (redirect) begin
         pc_d         = {redirect_pc[15:1], 1'b0};
         valid_d      = 1'b0;
         skid_valid_d = 1'b0;
         state_d      = S_REQ;
         // Only a request still in flight needs its reply discarded.
         squash_d     = in_req && !mem_resp;
      end else begin
         if (resp_hit && squash_q) begin
            squash_d = 1'b0;
         end
         if (resp_take) begin
            pc_d = next_addr;
            if (!valid_q || !stall) begin
               instr_d = mem_rdata;
               pcout_d = next_addr;
               valid_d = 1'b1;
            end else begin
               skid_valid_d = 1'b1;
               skid_instr_d = mem_rdata;
               skid_pc_d    = next_addr;
               state_d      = S_DRAIN;
            end
         end
         if (retire && skid_valid_q) begin
            instr_d      = skid_instr_q;
            pcout_d      = skid_pc_q;
            valid_d      = 1'b1;
            skid_valid_d = 1'b0;
            state_d      = S_REQ;
         end else if (retire && !resp_take) begin
            valid_d = 1'b0;
         end
         if (state_q == S_IDLE) begin
            state_d = S_REQ;
         end
      end

      // A pending request keeps its address; any new one uses the new pc.
      holding = in_req && !mem_resp;
      if (state_d == S_REQ && !holding) begin
         req_addr_d = pc_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         pc_q         <= RESET_PC_AL;
         req_addr_q   <= 16'h0000;
         squash_q     <= 1'b0;
         skid_valid_q <= 1'b0;
         skid_instr_q <= 16'h0000;
         skid_pc_q    <= 16'h0000;
         instr_q      <= 16'h0000;
         pcout_q      <= 16'h0000;
         valid_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         req_addr_q   <= req_addr_d;
         squash_q     <= squash_d;
         skid_valid_q <= skid_valid_d;
         skid_instr_q <= skid_instr_d;
         skid_pc_q    <= skid_pc_d;
         instr_q      <= instr_d;
         pcout_q      <= pcout_d;
         valid_q      <= valid_d;
      end
   end

   assign mem_read    = (state_q == S_REQ);
   assign mem_address = req_addr_q;
   assign instr_out   = instr_q;
   assign pc_out      = pcout_q;
   assign valid_out   = valid_q;

endmodule

// File: tb/tb_lc3b_fetch.sv
// tb_lc3b_fetch: directed self-checking bench for lc3b_fetch.
// Each task drives one scenario and checks outputs 1 time unit after posedge.
module tb_lc3b_fetch;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        mem_resp;
   logic [15:0] mem_rdata;
   logic        mem_read;
   logic [15:0] mem_address;
   logic [15:0] instr_out;
   logic [15:0] pc_out;
   logic        valid_out;

   int checks = 0;
   int errors = 0;

   lc3b_fetch #(.RESET_PC(16'h0000)) dut (
      .clk(clk),
      .reset(reset),
      .stall(stall),
      .redirect(redirect),
      .redirect_pc(redirect_pc),
      .mem_resp(mem_resp),
      .mem_rdata(mem_rdata),
      .mem_read(mem_read),
      .mem_address(mem_address),
      .instr_out(instr_out),
      .pc_out(pc_out),
      .valid_out(valid_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 16'h0000;
      mem_resp    = 1'b0;
      mem_rdata   = 16'h0000;
   endtask

   // Reset, release, and step once so the stage is in REQ at 0x0000.
   task automatic start();
      idle_inputs();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      cyc();
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      cyc();
      checks++;
      if ({valid_out, mem_read} !== 2'b00 || instr_out !== 16'h0 ||
          pc_out !== 16'h0 || mem_address !== 16'h0) begin
         errors++;
         $display("FAIL reset_outs got v=%b r=%b a=%h i=%h p=%h want all 0",
                  valid_out, mem_read, mem_address, instr_out, pc_out);
      end
      reset = 1'b0;
      cyc();
      checks++;
      if (mem_read !== 1'b1 || mem_address !== 16'h0000) begin
         errors++;
         $display("FAIL reset_first_req got r=%b a=%h want 1/0000",
                  mem_read, mem_address);
      end
   endtask

   task automatic test_back_to_back();
      start();
      mem_resp  = 1'b1;
      mem_rdata = 16'h1234;
      cyc();
      checks++;
      if (valid_out !== 1'b1 || instr_out !== 16'h1234 || pc_out !== 16'h0002) begin
         errors++;
         $display("FAIL b2b_first got v=%b i=%h p=%h want 1/1234/0002",
                  valid_out, instr_out, pc_out);
      end
      checks++;
      if (mem_read !== 1'b1 || mem_address !== 16'h0002) begin
         errors++;
         $display("FAIL b2b_addr2 got r=%b a=%h want 1/0002", mem_read, mem_address);
      end
      mem_rdata = 16'h5678;
      cyc();
      checks++;
      if (valid_out !== 1'b1 || instr_out !== 16'h5678 || pc_out !== 16'h0004) begin
         errors++;
         $display("FAIL b2b_second got v=%b i=%h p=%h want 1/5678/0004",
                  valid_out, instr_out, pc_out);
      end
      mem_resp = 1'b0;
      cyc();
      checks++;
      if (valid_out !== 1'b0 || mem_address !== 16'h0004) begin
         errors++;
         $display("FAIL b2b_empty got v=%b a=%h want 0/0004", valid_out, mem_address);
      end
   endtask

   // Leaves the stage in DRAIN: output 1111/0002, skid 2222/0004, stall=1.
   task automatic fill_skid();
      start();
      stall     = 1'b1;
      mem_resp  = 1'b1;
      mem_rdata = 16'h1111;
      cyc();
      mem_rdata = 16'h2222;
      cyc();
      mem_resp  = 1'b0;
   endtask

   task automatic test_stall_skid();
      fill_skid();
      checks++;
      if (mem_read !== 1'b0 || valid_out !== 1'b1 ||
          instr_out !== 16'h1111 || pc_out !== 16'h0002) begin
         errors++;
         $display("FAIL skid_drain got r=%b v=%b i=%h p=%h want 0/1/1111/0002",
                  mem_read, valid_out, instr_out, pc_out);
      end
      mem_resp  = 1'b1;
      mem_rdata = 16'hBAD0;
      cyc();
      mem_resp  = 1'b0;
      checks++;
      if (mem_read !== 1'b0 || instr_out !== 16'h1111 || pc_out !== 16'h0002) begin
         errors++;
         $display("FAIL skid_frozen got r=%b i=%h p=%h want 0/1111/0002",
                  mem_read, instr_out, pc_out);
      end
      stall = 1'b0;
      cyc();
      checks++;
      if (valid_out !== 1'b1 || instr_out !== 16'h2222 || pc_out !== 16'h0004) begin
         errors++;
         $display("FAIL skid_release got v=%b i=%h p=%h want 1/2222/0004",
                  valid_out, instr_out, pc_out);
      end
      checks++;
      if (mem_read !== 1'b1 || mem_address !== 16'h0004) begin
         errors++;
         $display("FAIL skid_rereq got r=%b a=%h want 1/0004", mem_read, mem_address);
      end
      cyc();
      checks++;
      if (valid_out !== 1'b0) begin
         errors++;
         $display("FAIL skid_retired got v=%b want 0", valid_out);
      end
   endtask

   task automatic test_redirect_squash();
      start();
      mem_resp  = 1'b1;
      mem_rdata = 16'h1234;
      cyc();
      mem_resp    = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 16'h3001;
      cyc();
      redirect = 1'b0;
      checks++;
      if (valid_out !== 1'b0 || mem_read !== 1'b1 || mem_address !== 16'h0002) begin
         errors++;
         $display("FAIL sq_hold got v=%b r=%b a=%h want 0/1/0002",
                  valid_out, mem_read, mem_address);
      end
      cyc();
      checks++;
      if (mem_address !== 16'h0002 || valid_out !== 1'b0) begin
         errors++;
         $display("FAIL sq_wait got a=%h v=%b want 0002/0", mem_address, valid_out);
      end
      mem_resp  = 1'b1;
      mem_rdata = 16'hDEAD;
      cyc();
      checks++;
      if (valid_out !== 1'b0 || mem_read !== 1'b1 || mem_address !== 16'h3000) begin
         errors++;
         $display("FAIL sq_drop got v=%b r=%b a=%h want 0/1/3000",
                  valid_out, mem_read, mem_address);
      end
      mem_rdata = 16'h600D;
      cyc();
      mem_resp  = 1'b0;
      checks++;
      if (valid_out !== 1'b1 || instr_out !== 16'h600D || pc_out !== 16'h3002) begin
         errors++;
         $display("FAIL sq_target got v=%b i=%h p=%h want 1/600d/3002",
                  valid_out, instr_out, pc_out);
      end
   endtask

   task automatic test_redirect_same_cycle();
      fill_skid();
      redirect    = 1'b1;
      redirect_pc = 16'h4444;
      mem_resp    = 1'b1;
      mem_rdata   = 16'hBAD1;
      cyc();
      redirect = 1'b0;
      checks++;
      if (valid_out !== 1'b0 || mem_read !== 1'b1 || mem_address !== 16'h4444) begin
         errors++;
         $display("FAIL rs_drain got v=%b r=%b a=%h want 0/1/4444",
                  valid_out, mem_read, mem_address);
      end
      stall     = 1'b0;
      mem_rdata = 16'h7777;
      cyc();
      mem_resp = 1'b0;
      checks++;
      if (valid_out !== 1'b1 || instr_out !== 16'h7777 || pc_out !== 16'h4446) begin
         errors++;
         $display("FAIL rs_nosquash got v=%b i=%h p=%h want 1/7777/4446",
                  valid_out, instr_out, pc_out);
      end
      cyc();
      checks++;
      if (valid_out !== 1'b0) begin
         errors++;
         $display("FAIL rs_skid_empty got v=%b want 0", valid_out);
      end
      // Redirect racing a live response while in REQ.
      start();
      redirect    = 1'b1;
      redirect_pc = 16'h5555;
      mem_resp    = 1'b1;
      mem_rdata   = 16'hBAD2;
      cyc();
      redirect  = 1'b0;
      checks++;
      if (valid_out !== 1'b0 || mem_read !== 1'b1 || mem_address !== 16'h5554) begin
         errors++;
         $display("FAIL rq_drop got v=%b r=%b a=%h want 0/1/5554",
                  valid_out, mem_read, mem_address);
      end
      mem_rdata = 16'h0101;
      cyc();
      mem_resp = 1'b0;
      checks++;
      if (valid_out !== 1'b1 || instr_out !== 16'h0101 || pc_out !== 16'h5556) begin
         errors++;
         $display("FAIL rq_next got v=%b i=%h p=%h want 1/0101/5556",
                  valid_out, instr_out, pc_out);
      end
   endtask

   task automatic test_wrap();
      start();
      redirect    = 1'b1;
      redirect_pc = 16'hFFFF;
      mem_resp    = 1'b1;
      mem_rdata   = 16'hBAD3;
      cyc();
      redirect = 1'b0;
      checks++;
      if (mem_address !== 16'hFFFE) begin
         errors++;
         $display("FAIL wrap_addr got a=%h want fffe", mem_address);
      end
      mem_rdata = 16'hABCD;
      cyc();
      mem_resp = 1'b0;
      checks++;
      if (valid_out !== 1'b1 || instr_out !== 16'hABCD || pc_out !== 16'h0000 ||
          mem_address !== 16'h0000) begin
         errors++;
         $display("FAIL wrap_pc got v=%b i=%h p=%h a=%h want 1/abcd/0000/0000",
                  valid_out, instr_out, pc_out, mem_address);
      end
   endtask

   task automatic test_reset_mid();
      start();
      mem_resp  = 1'b1;
      mem_rdata = 16'h1234;
      cyc();
      mem_resp  = 1'b0;
      reset     = 1'b1;
      #1;
      checks++;
      if ({valid_out, mem_read} !== 2'b00 || instr_out !== 16'h0 ||
          pc_out !== 16'h0 || mem_address !== 16'h0) begin
         errors++;
         $display("FAIL rm_async got v=%b r=%b a=%h i=%h p=%h want all 0",
                  valid_out, mem_read, mem_address, instr_out, pc_out);
      end
      cyc();
      reset     = 1'b0;
      mem_resp  = 1'b1;
      mem_rdata = 16'hBAD4;
      #1;
      checks++;
      if (mem_read !== 1'b0 || valid_out !== 1'b0) begin
         errors++;
         $display("FAIL rm_idle got r=%b v=%b want 0/0", mem_read, valid_out);
      end
      cyc();
      mem_resp = 1'b0;
      checks++;
      if (valid_out !== 1'b0 || mem_read !== 1'b1 || mem_address !== 16'h0000) begin
         errors++;
         $display("FAIL rm_stray got v=%b r=%b a=%h want 0/1/0000",
                  valid_out, mem_read, mem_address);
      end
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_back_to_back();
      test_stall_skid();
      test_redirect_squash();
      test_redirect_same_cycle();
      test_wrap();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
